// File: rtl/i2s_pcm_tx.sv
// I2S / PCM Format A serial transmitter with a one-deep holding register.
// All pad outputs are registered and change only on the SCLK falling edge.
module i2s_pcm_tx #(
  parameter int BITS       = 32,
  parameter int FRAME_BITS = 64,
  parameter int CLK_DIV    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] audio_i,
  input  logic            valid,
  output logic            ready,
  output logic            pad_sclk,
  output logic            pad_lrclk,
  output logic            pad_dout,
  output logic            frame,
  output logic            underrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(FRAME_BITS);

  logic [DW-1:0]   div_q, div_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic            sclk_q, sclk_d;
  logic            lrclk_q, lrclk_d;
  logic            dout_q, dout_d;
  logic            full_q, full_d;
  logic [BITS-1:0] hold_q, hold_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic            wrap, fall, load, xfer;

  always_comb begin
    wrap     = (div_q == DW'(CLK_DIV - 1));
    fall     = wrap & sclk_q;
    load     = fall & (slot_q == SW'(FRAME_BITS - 1));
    ready    = !full_q | load;
    xfer     = valid & ready;
    frame    = load;
    underrun = load & !full_q;
    div_d    = wrap ? '0 : div_q + 1'b1;
    sclk_d   = sclk_q ^ wrap;
    slot_d   = slot_q;
    lrclk_d  = lrclk_q;
    dout_d   = dout_q;
    full_d   = full_q;
    hold_d   = hold_q;
    shift_d  = shift_q;
    if (xfer) begin
      hold_d = audio_i;
      full_d = 1'b1;
    end
    if (fall) begin
      slot_d  = load ? '0 : slot_q + 1'b1;
      lrclk_d = load;
      dout_d  = 1'b0;
      // slot n carries bit BITS-n: one-slot MSB delay
      for (int i = 0; i < BITS; i++) begin
        if (slot_d == SW'(BITS - i)) dout_d = shift_q[i];
      end
      if (load) begin
        if (full_q) shift_d = hold_q;
        full_d = xfer;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      slot_q  <= SW'(FRAME_BITS - 1);
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      dout_q  <= 1'b0;
      full_q  <= 1'b0;
      hold_q  <= '0;
      shift_q <= '0;
    end else begin
      div_q   <= div_d;
      slot_q  <= slot_d;
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
      dout_q  <= dout_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
    end
  end

  assign pad_sclk  = sclk_q;
  assign pad_lrclk = lrclk_q;
  assign pad_dout  = dout_q;

endmodule

// File: tb/tb_i2s_pcm_tx.sv
// Directed bench for i2s_pcm_tx: default build plus a 16/32/2 build.
// Expected frames and timings are hand-computed constants.
module tb_i2s_pcm_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a1;
  logic        v1;
  logic        r1, s1, l1, d1, f1, u1;
  logic [15:0] a2;
  logic        v2;
  logic        r2, s2, l2, d2, f2, u2;

  i2s_pcm_tx u_dut (
    .clk(clk), .rst(rst), .audio_i(a1), .valid(v1), .ready(r1),
    .pad_sclk(s1), .pad_lrclk(l1), .pad_dout(d1),
    .frame(f1), .underrun(u1)
  );

  i2s_pcm_tx #(.BITS(16), .FRAME_BITS(32), .CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .audio_i(a2), .valid(v2), .ready(r2),
    .pad_sclk(s2), .pad_lrclk(l2), .pad_dout(d2),
    .frame(f2), .underrun(u2)
  );

  logic sel = 1'b0;
  wire  lr_m  = sel ? l2 : l1;
  wire  do_m  = sel ? d2 : d1;
  wire  fr_m  = sel ? f2 : f1;
  wire  ur_m  = sel ? u2 : u1;
  wire  rdy_m = sel ? r2 : r1;

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    v1  = 1'b0;
    v2  = 1'b0;
    repeat (3) tick;
    check("rst_outs", {58'd0, s1, l1, d1, f1, u1, r1}, 64'b000001);
    rst = 1'b0;
  endtask

  task automatic wait_load(output int n, output logic ur,
                           output int rdy_hi);
    n = 0;
    rdy_hi = 0;
    do begin
      tick;
      n++;
      if (!fr_m && rdy_m) rdy_hi++;
    end while (!fr_m && n < 5000);
    if (!fr_m) check("load_timeout", 0, 1);
    ur = ur_m;
  endtask

  task automatic read_frame(input int fb, input int bits, input int cd,
                            output logic [31:0] w, output int lrb,
                            output int tail, output int rdl,
                            output logic d0);
    w = 0; lrb = 0; tail = 0; rdl = 0; d0 = 1'b0;
    for (int s = 0; s < fb; s++) begin
      if (s == 0) tick;
      else repeat (2 * cd) tick;
      if (lr_m !== (s == 0)) lrb++;
      if (!rdy_m) rdl++;
      if (s == 0) d0 = do_m;
      else if (s <= bits) w = {w[30:0], do_m};
      else if (do_m) tail++;
    end
  endtask

  int          n, hi, lrb, tail, rdl, t0, t1, cnt;
  logic        ur, dz, prev;
  logic [31:0] w;

  initial begin
    a1 = '0; v1 = 1'b0; a2 = '0; v2 = 1'b0;

    // one frame of A5A50F0F, valid held until the first load
    do_reset;
    v1 = 1'b1; a1 = 32'hA5A5_0F0F;
    tick;
    check("ready_after_wr", 64'(r1), 1'b0);
    wait_load(n, ur, hi);
    v1 = 1'b0;
    check("first_load_cyc", 64'(n), 6);
    check("t1_underrun", 64'(ur), 0);
    read_frame(64, 32, 4, w, lrb, tail, rdl, dz);
    check("t1_word", 64'(w), 32'hA5A5_0F0F);
    check("t1_lrclk", 64'(lrb), 0);
    check("t1_tail", 64'(tail), 0);
    check("t1_slot0", 64'(dz), 0);

    // no writes: underrun every load, silent, always ready
    do_reset;
    wait_load(n, ur, hi);
    check("first_load_cyc2", 64'(n), 7);
    check("t2_ur0", 64'(ur), 1);
    read_frame(64, 32, 4, w, lrb, tail, rdl, dz);
    check("t2_word", 64'(w), 0);
    check("t2_tail", 64'(tail), 0);
    check("t2_ready", 64'(rdl), 0);
    wait_load(n, ur, hi);
    check("t2_ur1", 64'(ur), 1);

    // single write is retransmitted with underrun
    do_reset;
    v1 = 1'b1; a1 = 32'h8000_0001;
    tick;
    v1 = 1'b0;
    wait_load(n, ur, hi);
    check("t3_ur0", 64'(ur), 0);
    read_frame(64, 32, 4, w, lrb, tail, rdl, dz);
    check("t3_word0", 64'(w), 32'h8000_0001);
    wait_load(n, ur, hi);
    check("t3_ur1", 64'(ur), 1);
    read_frame(64, 32, 4, w, lrb, tail, rdl, dz);
    check("t3_word1", 64'(w), 32'h8000_0001);

    // back-to-back writes, second accepted in the load cycle
    do_reset;
    v1 = 1'b1; a1 = 32'h1111_1111;
    tick;
    check("t4_ready_lo", 64'(r1), 0);
    a1 = 32'h2222_2222;
    wait_load(n, ur, hi);
    check("t4_rdy_hi_pre", 64'(hi), 0);
    check("t4_ready_load", 64'(r1), 1);
    check("t4_ur0", 64'(ur), 0);
    read_frame(64, 32, 4, w, lrb, tail, rdl, dz);
    v1 = 1'b0;
    check("t4_word0", 64'(w), 32'h1111_1111);
    check("t4_full_frame", 64'(rdl), 64);
    wait_load(n, ur, hi);
    check("t4_ur1", 64'(ur), 0);
    read_frame(64, 32, 4, w, lrb, tail, rdl, dz);
    check("t4_word1", 64'(w), 32'h2222_2222);

    // reset in slot 20 while SCLK high and DOUT high
    do_reset;
    v1 = 1'b1; a1 = 32'hFFFF_FFFF;
    tick;
    v1 = 1'b0;
    wait_load(n, ur, hi);
    tick;
    repeat (20 * 8) tick;
    repeat (4) tick;
    check("t5_pre", 64'({s1, d1}), 2'b11);
    #2 rst = 1'b1;
    #1 check("t5_async", 64'({s1, l1, d1, f1, u1}), 0);
    repeat (3) tick;
    rst = 1'b0;
    wait_load(n, ur, hi);
    check("t5_load_cyc", 64'(n), 7);
    tick;
    check("t5_fall", 64'({s1, l1}), 2'b01);

    // 16-bit / 32-slot / div-2 build
    do_reset;
    sel = 1'b1;
    v2 = 1'b1; a2 = 16'hBEEF;
    wait_load(n, ur, hi);
    v2 = 1'b0;
    check("t6_load_cyc", 64'(n), 3);
    read_frame(32, 16, 2, w, lrb, tail, rdl, dz);
    check("t6_word", 64'(w), 32'h0000_BEEF);
    check("t6_tail", 64'(tail), 0);
    check("t6_lrclk", 64'(lrb), 0);
    wait_load(n, ur, hi);
    wait_load(n, ur, hi);
    check("t6_lr_period", 64'(n), 128);
    t0 = -1; t1 = -1; cnt = 0; prev = s2;
    while (t1 < 0 && cnt < 100) begin
      tick;
      cnt++;
      if (s2 && !prev) begin
        if (t0 < 0) t0 = cnt;
        else t1 = cnt;
      end
      prev = s2;
    end
    check("t6_sclk_period", 64'(t1 - t0), 4);
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
